// File: rtl/apb_fifo_ctrl.sv
// rtl/apb_fifo_ctrl.sv - APB slave FIFO peripheral with status, thresholds, sticky errors and IRQ
// One wait state per transfer; every side effect commits on the edge that ends the decode cycle.
module apb_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [4:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        IRQ
);
  localparam int PTR_W = CNT_W - 1;

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t              state, state_next;
  logic                access;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    af_thr, ae_thr;
  logic [DATA_W-1:0]   last_wr;
  logic                en_af, en_ae, en_err;
  logic                ovf, udf;
  logic                empty, full, almost_full, almost_empty, irq_next;
  logic [31:0]         fsr, thr_word, rdata_next;
  logic                err_next, push, pop, flush, ctrl_we, thr_we, fwd_we;
  logic                ovf_set, udf_set, ovf_clr, udf_clr;
  logic                unused_bits;

  assign unused_bits = ^{PADDR[1:0], PWDATA};

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_next;
  end

  // ACK always returns to IDLE, so a master still holding PSEL/PENABLE there is not re-executed
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (PSEL && PENABLE) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    PREADY = (state == ACK);
    access = (state == IDLE) && PSEL && PENABLE;
  end

  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(DEPTH));
  assign almost_full  = (count >= af_thr);
  assign almost_empty = (count <= ae_thr);
  assign irq_next     = (en_af & almost_full) | (en_ae & almost_empty) | (en_err & (ovf | udf));

  always_comb begin
    fsr = '0;
    fsr[0] = empty;
    fsr[1] = full;
    fsr[2] = almost_empty;
    fsr[3] = almost_full;
    fsr[4] = ovf;
    fsr[5] = udf;
    fsr[16 +: CNT_W] = count;
    thr_word = '0;
    thr_word[0 +: CNT_W]  = af_thr;
    thr_word[16 +: CNT_W] = ae_thr;
  end

  always_comb begin
    rdata_next = '0;
    err_next   = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;
    ctrl_we    = 1'b0;
    thr_we     = 1'b0;
    fwd_we     = 1'b0;
    ovf_set    = 1'b0;
    udf_set    = 1'b0;
    ovf_clr    = 1'b0;
    udf_clr    = 1'b0;
    if (access) begin
      case (PADDR[4:2])
        3'd0: if (!PWRITE) rdata_next = fsr;
        3'd1: begin
          if (PWRITE) begin
            fwd_we = 1'b1;
            if (full) begin
              ovf_set  = 1'b1;
              err_next = 1'b1;
            end else begin
              push = 1'b1;
            end
          end else begin
            rdata_next = 32'(last_wr);
          end
        end
        3'd2: begin
          if (!PWRITE) begin
            if (empty) begin
              udf_set  = 1'b1;
              err_next = 1'b1;
            end else begin
              pop        = 1'b1;
              rdata_next = 32'(mem[rd_ptr]);
            end
          end
        end
        3'd3: begin
          if (PWRITE) begin
            ctrl_we = 1'b1;
            flush   = PWDATA[3];
          end else begin
            rdata_next = 32'({en_err, en_ae, en_af});
          end
        end
        3'd4: begin
          if (PWRITE) thr_we = 1'b1;
          else        rdata_next = thr_word;
        end
        3'd5: begin
          if (PWRITE) begin
            ovf_clr = PWDATA[4];
            udf_clr = PWDATA[5];
          end
        end
        default: err_next = 1'b1;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (push) mem[wr_ptr] <= PWDATA[DATA_W-1:0];
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
      IRQ     <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      af_thr  <= CNT_W'(DEPTH - 1);
      ae_thr  <= CNT_W'(1);
      last_wr <= '0;
      en_af   <= 1'b0;
      en_ae   <= 1'b0;
      en_err  <= 1'b0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else begin
      if (access) begin
        PRDATA  <= rdata_next;
        PSLVERR <= err_next;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        count  <= count + CNT_W'(1);
      end else if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        count  <= count - CNT_W'(1);
      end
      if (ctrl_we) {en_err, en_ae, en_af} <= PWDATA[2:0];
      if (thr_we) begin
        af_thr <= PWDATA[0 +: CNT_W];
        ae_thr <= PWDATA[16 +: CNT_W];
      end
      if (fwd_we) last_wr <= PWDATA[DATA_W-1:0];
      // a same-cycle status event beats the software clear
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (udf_set)      udf <= 1'b1;
      else if (udf_clr) udf <= 1'b0;
      IRQ <= irq_next;
    end
  end

endmodule

// File: doc/apb_fifo_ctrl.md
# apb_fifo_ctrl

Parametrised APB-slave FIFO peripheral: the next generation of the team's 8-bit FIFO peripheral, with configurable data width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags, flush, PSLVERR and a level interrupt. It sits on the APB bus as a single slave. The processor pushes by writing FWD and pops by reading FRD.

## Interface
- DATA_W, 8: FIFO word width, 1..32; PWDATA/PRDATA use bits [DATA_W-1:0], upper bits 0 on read.
- DEPTH, 16: FIFO entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1: occupancy count width (derived, not overridden).
- PCLK  in  1  single clock; all state updates on rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- PADDR  in  5  byte address; decode on PADDR[4:2].
- PWDATA  in  32  write data.
- PWRITE  in  1  1 = write, 0 = read.
- PENABLE  in  1  APB access phase.
- PSEL  in  1  slave select.
- PRDATA  out  32  read data; valid while PREADY=1.
- PREADY  out  1  one-cycle transfer-complete pulse.
- PSLVERR  out  1  error response, valid only with PREADY.
- IRQ  out  1  registered level interrupt.

## Operation
- Register map (PADDR[4:2]):
  - 0 FSR (RO): [0] empty, [1] full, [2] almost_empty, [3] almost_full, [4] ovf sticky, [5] udf sticky, [16+CNT_W-1:16] count.
  - 1 FWD (RW): a write pushes PWDATA[DATA_W-1:0] and stores it as the last-written value. A read returns the last-written value without pushing.
  - 2 FRD (RO): a read returns the head word and pops it. Writes are ignored.
  - 3 CTRL (RW): [0] en_af, [1] en_ae, [2] en_err, [3] flush (write 1 = flush; self-clearing, reads 0).
  - 4 THR (RW): [CNT_W-1:0] af_thr, [16+CNT_W-1:16] ae_thr.
  - 5 ICLR (WO): write 1 to [4] clears ovf; write 1 to [5] clears udf. Reads 0.
  - 6, 7: unmapped.
- almost_full = count >= af_thr; almost_empty = count <= ae_thr. Both are combinational from the current count and thresholds.
- Push while full: the data is dropped, ovf is set, and PSLVERR=1 on that transfer. The count is unchanged.
- Pop while empty: PRDATA=0, udf is set, PSLVERR=1. The pointers are unchanged.
- Unmapped address, read or write: PRDATA=0, PSLVERR=1, no side effects.
- Flush: read and write pointers and the count go to 0. Sticky flags, CTRL enables and THR are preserved.
- IRQ_next = (en_af & almost_full) | (en_ae & almost_empty) | (en_err & (ovf | udf)).
- Pointers are CNT_W-1 bits and wrap modulo DEPTH. The count is tracked separately, range 0..DEPTH.

## Timing
- Slave FSM states are IDLE and ACK.
  - IDLE: on PSEL & PENABLE, decode the access, register PRDATA/PSLVERR, set PREADY_next=1, and go to ACK.
  - ACK: PREADY=1 for exactly one cycle, then return to IDLE unconditionally.
- Every transfer has exactly one wait state: PREADY rises the cycle after PENABLE is first seen high.
- A new access is not accepted in ACK. A master holding PSEL & PENABLE during ACK is the same transfer and is not re-executed.
- Push, pop, flush, ICLR clear and CTRL/THR updates commit on the rising edge that ends the IDLE decode cycle. Effects are visible in FSR on the next transfer.
- FRD data is the head value sampled in the decode cycle, i.e. the pre-pop value.
- IRQ is registered: it changes one cycle after the status or enable change that causes it.
- If a status event and an ICLR clear of the same sticky bit land in the same cycle, the set wins.
- Reset values:
  - PRDATA=0, PREADY=0, PSLVERR=0, IRQ=0, state=IDLE.
  - Pointers and count 0 (empty=1, almost_empty=1).
  - CTRL=0, FWD last-written=0, ovf=udf=0.
  - af_thr=DEPTH-1, ae_thr=1.
- PRESET asserted mid-transfer aborts it: PREADY drops immediately and no push or pop commits.

## Test plan
- Reset, then read FSR -> 0x0000_0005 (empty, almost_empty, count 0). PREADY pulses once, 2 cycles after the PSEL setup cycle.
- Write FWD 0x11, 0x22, 0x33, then read FRD three times -> 0x11, 0x22, 0x33. FSR count goes 3→0. Then read FRD again -> PRDATA=0, PSLVERR=1, FSR[5]=1.
- DEPTH=16: 16 pushes -> full=1, almost_full=1, count=16. 17th push -> PSLVERR=1, ovf=1, and a subsequent read of all 16 entries is unchanged. Pointers wrap correctly on an interleaved push/pop over 40 operations.
- THR af_thr=4, CTRL en_af=1, push 4 words -> IRQ rises one cycle after the 4th push commits. Pop 1 -> IRQ falls.
- en_err=1 with ovf set -> IRQ=1. ICLR write 0x10 -> ovf=0, IRQ=0 next cycle. CTRL flush with 5 entries -> count=0, empty=1, THR and CTRL enables retained.
- Access to PADDR 0x18 -> PRDATA=0, PSLVERR=1, no state change. PRESET pulsed during ACK -> all outputs return to reset values, and no pop occurs.
